// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// ----------------------
// Control sequencer for the multicycle MIPS datapath. It moves one shared
// ALU, one unified instruction/data memory and the register file through
// fetch, decode, execute, memory and writeback cycles. Supported
// instructions are R_TYPE, ADDI, BEQ, LW, SW and J. Memory accesses use a
// ready handshake, so the FSM waits in FETCH, MEMRD or MEMWR until
// MemReady is high.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   OPCode     : instruction register bits [31:26]
//   Funct      : instruction register bits [5:0]
//   Zero       : ALU zero flag (used by BEQ)
//   MemReady   : memory finished the current read/write this cycle
//   IorD       : memory address select, 0 = PC, 1 = ALUOut
//   MemRead    : memory read request
//   MemWrite   : memory write request
//   IRWrite    : instruction register load
//   RegDst     : destination register select, 0 = rt, 1 = rd
//   MemtoReg   : writeback select, 0 = ALUOut, 1 = data register
//   RegWrite   : register file write enable
//   ALUSrcA    : ALU operand A, 0 = PC, 1 = register A
//   ALUSrcB    : ALU operand B, 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   ALUCtl     : ALU operation, 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT
//   PCSrc      : next-PC select, 00 = ALU result, 01 = ALUOut, 10 = jump
//   PCWrite    : PC write enable
//   State      : current state encoding (debug / verification)
//   InstrDone  : pulse in the last cycle of each instruction
//   Illegal    : high while the FSM sits in TRAP

module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtl,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_d;

  // State register; reset wins over every transition, including TRAP and
  // memory stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Unused codes 13-15 fall into the default and recover
  // to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (OPCode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = TRAP;
        endcase
      end
      // Only LW and SW reach MEMADR, so anything other than SW is a load.
      MEMADR: state_d = (OPCode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MemReady ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = MemReady ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      JUMP:   state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Output decode. Mostly Moore from state_q; the only input-dependent
  // terms are the FETCH handshake strobes, the MEMWR done pulse, the BEQ
  // PC write and the R-type ALU operation.
  always_comb begin
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUCtl    = ALU_ADD;
    PCSrc     = 2'b00;
    PCWrite   = 1'b0;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Latch IR and PC+4 only once memory has actually returned data.
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100000: ALUCtl = ALU_ADD;
          6'b100010: ALUCtl = ALU_SUB;
          6'b100100: ALUCtl = ALU_AND;
          6'b100101: ALUCtl = ALU_OR;
          6'b101010: ALUCtl = ALU_SLT;
          default:   ALUCtl = ALU_AND;
        endcase
      end
      ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUCtl    = ALU_SUB;
        PCSrc     = 2'b01;
        PCWrite   = Zero;
        InstrDone = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      JUMP: begin
        PCSrc     = 2'b10;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
      end
      TRAP: begin
        Illegal = 1'b1;
      end
      default: begin
      end
    endcase
    // Hold every side-effecting strobe low while reset is asserted so the
    // datapath cannot be disturbed before the state register settles.
    if (!rst_n) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
// -------------------------
// Directed self-checking bench for multicycle_control_fsm. Inputs change
// 1 ns after each rising edge and outputs are read 1 ns later, well away
// from the next active edge.

module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] OPCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUCtl;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic [3:0] State;
  logic       InstrDone;
  logic       Illegal;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .OPCode(OPCode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUCtl(ALUCtl), .PCSrc(PCSrc), .PCWrite(PCWrite), .State(State),
    .InstrDone(InstrDone), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive instruction fields and handshake inputs, then let them settle.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy);
    OPCode   = op;
    Funct    = fn;
    Zero     = z;
    MemReady = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH with MemReady=1 until InstrDone,
  // collecting what the bench needs to judge it.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input string tag,
                          output int cycles, output logic sawRegWrite,
                          output logic sawMemWrite, output logic memWrIorD,
                          output logic donePcWrite, output logic [1:0] donePcSrc,
                          output logic [2:0] execAluCtl);
    logic done;
    done        = 1'b0;
    cycles      = 0;
    sawRegWrite = 1'b0;
    sawMemWrite = 1'b0;
    memWrIorD   = 1'b0;
    donePcWrite = 1'b0;
    donePcSrc   = 2'b00;
    execAluCtl  = 3'b000;
    applyStimulus(op, fn, z, 1'b1);
    while (!done && cycles < 20) begin
      cycles++;
      if (RegWrite) sawRegWrite = 1'b1;
      if (MemWrite) begin
        sawMemWrite = 1'b1;
        memWrIorD   = IorD;
      end
      if (State == 4'd6) execAluCtl = ALUCtl;
      if (InstrDone) begin
        done        = 1'b1;
        donePcWrite = PCWrite;
        donePcSrc   = PCSrc;
      end
      tick();
      #1;
    end
    if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int         cyc;
  logic       sRw, sMw, mIorD, dPcw;
  logic [1:0] dPcs;
  logic [2:0] eAlu;
  int         irwCount;
  logic [3:0] lwStates [10];
  logic       lwReady  [10];
  logic [5:0] sweepFn  [5];
  logic [2:0] sweepAlu [5];

  initial begin
    lwStates = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    lwReady  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sweepFn  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    sweepAlu = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b000};

    // Reset: state returns to FETCH and strobes are held low.
    rst_n = 1'b0;
    applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_state", {28'd0, State}, 32'd0);
    checkOutput("rst_memread", {31'd0, MemRead}, 32'd0);
    checkOutput("rst_irwrite", {31'd0, IRWrite}, 32'd0);
    checkOutput("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
    rst_n = 1'b1;
    #1;

    // ADD: 0,1,6,7,0.
    checkOutput("add_fetch_state", {28'd0, State}, 32'd0);
    checkOutput("add_fetch_memread", {31'd0, MemRead}, 32'd1);
    checkOutput("add_fetch_irwrite", {31'd0, IRWrite}, 32'd1);
    checkOutput("add_fetch_srcb", {30'd0, ALUSrcB}, 32'd1);
    tick();
    checkOutput("add_decode_state", {28'd0, State}, 32'd1);
    checkOutput("add_decode_srcb", {30'd0, ALUSrcB}, 32'd3);
    checkOutput("add_decode_regwrite", {31'd0, RegWrite}, 32'd0);
    tick();
    checkOutput("add_exec_state", {28'd0, State}, 32'd6);
    checkOutput("add_exec_aluctl", {29'd0, ALUCtl}, 32'd2);
    checkOutput("add_exec_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("add_exec_done", {31'd0, InstrDone}, 32'd0);
    tick();
    checkOutput("add_wb_state", {28'd0, State}, 32'd7);
    checkOutput("add_wb_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("add_wb_regdst", {31'd0, RegDst}, 32'd1);
    checkOutput("add_wb_done", {31'd0, InstrDone}, 32'd1);
    tick();
    checkOutput("add_back_state", {28'd0, State}, 32'd0);
    checkOutput("add_back_done", {31'd0, InstrDone}, 32'd0);

    // LW with 2 FETCH waits and 3 MEMRD waits: 10 cycles.
    irwCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(6'b100011, 6'b000000, 1'b0, lwReady[i]);
      checkOutput($sformatf("lw_state_c%0d", i), {28'd0, State}, {28'd0, lwStates[i]});
      if (lwStates[i] == 4'd0 || lwStates[i] == 4'd3)
        checkOutput($sformatf("lw_memread_c%0d", i), {31'd0, MemRead}, 32'd1);
      if (!lwReady[i])
        checkOutput($sformatf("lw_wait_wstrobe_c%0d", i),
                    {29'd0, RegWrite, PCWrite, IRWrite}, 32'd0);
      if (IRWrite) irwCount++;
      if (i == 9) begin
        checkOutput("lw_wb_regwrite", {31'd0, RegWrite}, 32'd1);
        checkOutput("lw_wb_memtoreg", {31'd0, MemtoReg}, 32'd1);
        checkOutput("lw_wb_done", {31'd0, InstrDone}, 32'd1);
      end
      tick();
    end
    checkOutput("lw_irwrite_count", irwCount, 32'd1);
    checkOutput("lw_end_state", {28'd0, State}, 32'd0);

    // BEQ taken and not taken.
    runInstr(6'b000100, 6'b000000, 1'b1, "beq_t", cyc, sRw, sMw, mIorD, dPcw, dPcs, eAlu);
    checkOutput("beq_t_cycles", cyc, 32'd3);
    checkOutput("beq_t_pcwrite", {31'd0, dPcw}, 32'd1);
    checkOutput("beq_t_pcsrc", {30'd0, dPcs}, 32'd1);
    runInstr(6'b000100, 6'b000000, 1'b0, "beq_n", cyc, sRw, sMw, mIorD, dPcw, dPcs, eAlu);
    checkOutput("beq_n_cycles", cyc, 32'd3);
    checkOutput("beq_n_pcwrite", {31'd0, dPcw}, 32'd0);

    // SW then J.
    runInstr(6'b101011, 6'b000000, 1'b0, "sw", cyc, sRw, sMw, mIorD, dPcw, dPcs, eAlu);
    checkOutput("sw_cycles", cyc, 32'd4);
    checkOutput("sw_memwrite", {31'd0, sMw}, 32'd1);
    checkOutput("sw_iord", {31'd0, mIorD}, 32'd1);
    checkOutput("sw_regwrite", {31'd0, sRw}, 32'd0);
    runInstr(6'b000010, 6'b000000, 1'b0, "j", cyc, sRw, sMw, mIorD, dPcw, dPcs, eAlu);
    checkOutput("j_cycles", cyc, 32'd3);
    checkOutput("j_pcsrc", {30'd0, dPcs}, 32'd2);
    checkOutput("j_pcwrite", {31'd0, dPcw}, 32'd1);

    // ADDI.
    runInstr(6'b001000, 6'b000000, 1'b0, "addi", cyc, sRw, sMw, mIorD, dPcw, dPcs, eAlu);
    checkOutput("addi_cycles", cyc, 32'd4);
    checkOutput("addi_regwrite", {31'd0, sRw}, 32'd1);

    // R-type funct sweep.
    for (int i = 0; i < 5; i++) begin
      runInstr(6'b000000, sweepFn[i], 1'b0, "rtype", cyc, sRw, sMw, mIorD, dPcw, dPcs, eAlu);
      checkOutput($sformatf("rtype_aluctl_%0d", i), {29'd0, eAlu}, {29'd0, sweepAlu[i]});
      checkOutput($sformatf("rtype_cycles_%0d", i), cyc, 32'd4);
    end

    // Illegal opcode: TRAP is sticky until reset.
    applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b1);
    checkOutput("trap_fetch_state", {28'd0, State}, 32'd0);
    tick();
    checkOutput("trap_decode_state", {28'd0, State}, 32'd1);
    tick();
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("trap_state_c%0d", i), {28'd0, State}, 32'd12);
      checkOutput($sformatf("trap_illegal_c%0d", i), {31'd0, Illegal}, 32'd1);
      checkOutput($sformatf("trap_strobes_c%0d", i),
                  {26'd0, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, InstrDone}, 32'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    checkOutput("trap_rst_illegal_low", {31'd0, Illegal}, 32'd0);
    tick();
    checkOutput("trap_rst_state", {28'd0, State}, 32'd0);
    checkOutput("trap_rst_illegal", {31'd0, Illegal}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_memread", {31'd0, MemRead}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
